crc_parallel_engine: RTL and testbench
======================================

Name: crc_parallel_engine

Overview:
Parametrised parallel CRC engine, the successor to the fixed 8-bit-input CRC-16 block.
- Configurable CRC width, polynomial, init, reflection, final XOR and input word width.
- Partial last words; framed valid/ready input; held result with handshake; receive-side residue check.
- Sits between a byte-stream datapath and framing/checking logic, in both TX (generate) and RX (check) paths.

Parameters:
CRC_WIDTH, 16, CRC register width (8..32)
POLY, 16'h1021, generator polynomial, normal form, implicit top bit omitted
INIT, 16'hFFFF, register value loaded at start of frame
REFIN, 0, 1 = reflect each input byte before processing
REFOUT, 0, 1 = reflect the whole register on output
XOROUT, 16'h0000, XORed into the reflected register to form crc_out
RESIDUE, 16'h0000, expected register value (after REFOUT, before XOROUT) for a frame that includes its own CRC
DATA_WIDTH, 8, input word width; multiple of 8, 8..64
NB, DATA_WIDTH/8, derived byte count; not user-set

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input beat valid
in_ready  out  1  engine accepts a beat this cycle
in_data  in  DATA_WIDTH  beat data; the first byte of the stream is in_data[7:0]
in_sof  in  1  first beat of frame
in_eof  in  1  last beat of frame
in_nbytes  in  $clog2(NB+1)  valid bytes in an eof beat (1..NB), low bytes valid; ignored when in_eof=0
crc_state  out  CRC_WIDTH  raw running register
out_valid  out  1  result available
out_ready  in  1  consumer takes result
crc_out  out  CRC_WIDTH  final CRC
crc_ok  out  1  residue match, qualified by out_valid

Behaviour:
- Reset (rst=1 at an edge):
  - State IDLE; register = INIT.
  - out_valid = 0, crc_out = 0, crc_ok = 0.
  - in_ready = 1 from the first cycle after reset.
  - Reset mid-frame or with a result pending discards everything; no output.
- Accept rule: a beat is accepted when in_valid && in_ready. Data is not consumed otherwise.
- States: IDLE, ACCUM, HOLD.
  - IDLE: beats without in_sof are dropped. They are accepted (in_ready=1) but have no effect.
  - IDLE, sof beat: processed with the register seeded from INIT. Go to ACCUM, or to HOLD if in_eof is also set.
  - ACCUM: each accepted beat updates the register. An eof beat goes to HOLD.
  - ACCUM, sof beat: restarts the frame; the beat is processed from INIT. The aborted frame produces no result.
  - HOLD: in_ready = 0; out_valid = 1; crc_out and crc_ok are stable. On out_ready, go to IDLE.
- Update: bytes are processed in order 0..k-1 (k = NB, or in_nbytes on an eof beat), combinationally within one cycle.
  - Each byte is reflected first if REFIN=1.
  - The register is MSB-first, shift-left, with POLY feedback.
  - in_nbytes of 0 or greater than NB on an eof beat is treated as NB.
- Result timing: out_valid rises the cycle after the eof beat is accepted (1-cycle latency).
  - crc_out = (REFOUT ? reflect(reg) : reg) ^ XOROUT.
  - crc_ok = ((REFOUT ? reflect(reg) : reg) == RESIDUE).
- crc_state updates each accepted beat. It is reloaded with INIT when the engine returns to IDLE.
- in_ready is combinational on state only, never on in_valid.
- Throughput: one beat per cycle in ACCUM. Minimum one bubble per frame (the HOLD cycle).

Decomposition:
- Package crc_pkg holds:
  - constants for the standard presets: CRC16_CCITT_FALSE, CRC16_ARC, CRC16_MODBUS, CRC32_ETH (poly/init/refin/refout/xorout/residue);
  - the reflect() function;
  - the state enum typedef.
- One sub-module, crc_byte_step: a combinational single-byte update (reg, byte -> reg), instantiated NB times in a chain with per-stage output taps, so the eof beat can select the tap at in_nbytes.

Test Plan:
- Default params (CCITT-FALSE), DATA_WIDTH=8, "123456789" (0x31..0x39), sof on byte 1, eof on byte 9, out_ready=1 -> out_valid one cycle after eof, crc_out=16'h29B1.
- POLY 8005, INIT 0, REFIN=REFOUT=1, XOROUT 0, DATA_WIDTH=32, "123456789" as 3 beats, last beat in_nbytes=1 -> crc_out=16'hBB3D. Same with INIT FFFF (MODBUS) -> 16'h4B37.
- CRC32_ETH preset, DATA_WIDTH=64: "123456789" -> crc_out=32'hCBF43926. The same data followed by bytes 26 39 F4 CB -> crc_ok=1. Flip one data bit -> crc_ok=0.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 throughout, crc_out stable, no beats consumed. Release -> next frame processes correctly.
- Frame with sof+eof on a single beat, back-to-back with a second frame; a mid-frame sof restart; rst=1 asserted mid-frame -> results match the reference model only for completed frames, no out_valid for the aborted frame, registers back at reset values after rst.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared types, standard CRC presets and the bit-reflection helper for the parallel CRC engine.
package crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } crc_state_e;

    typedef struct packed {
        logic [31:0] poly;
        logic [31:0] init;
        logic        refin;
        logic        refout;
        logic [31:0] xorout;
        logic [31:0] residue;
    } crc_preset_t;

    // Residue is the register after output reflection, before the final XOR.
    localparam crc_preset_t CRC16_CCITT_FALSE = '{poly: 32'h0000_1021, init: 32'h0000_FFFF,
        refin: 1'b0, refout: 1'b0, xorout: 32'h0000_0000, residue: 32'h0000_0000};
    localparam crc_preset_t CRC16_ARC = '{poly: 32'h0000_8005, init: 32'h0000_0000,
        refin: 1'b1, refout: 1'b1, xorout: 32'h0000_0000, residue: 32'h0000_0000};
    localparam crc_preset_t CRC16_MODBUS = '{poly: 32'h0000_8005, init: 32'h0000_FFFF,
        refin: 1'b1, refout: 1'b1, xorout: 32'h0000_0000, residue: 32'h0000_0000};
    localparam crc_preset_t CRC32_ETH = '{poly: 32'h04C1_1DB7, init: 32'hFFFF_FFFF,
        refin: 1'b1, refout: 1'b1, xorout: 32'hFFFF_FFFF, residue: 32'hDEBB_20E3};

    // Reverse the low w bits of v; bits at and above w come back zero.
    function automatic logic [31:0] reflect(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = {<<{v}};
        return r >> (32 - w);
    endfunction

endpackage

// File: rtl/crc_byte_step.sv
// Combinational single-byte CRC update: MSB-first, shift-left register with POLY feedback.
module crc_byte_step
    import crc_pkg::*;
#(
    parameter int                   CRC_WIDTH = 16,
    parameter logic [CRC_WIDTH-1:0] POLY      = 16'h1021,
    parameter bit                   REFIN     = 1'b0
) (
    input  logic [CRC_WIDTH-1:0] i_crc,
    input  logic [7:0]           i_byte,
    output logic [CRC_WIDTH-1:0] o_crc
);

    logic [7:0]           w_byte;
    logic [CRC_WIDTH-1:0] w_crc;

    // Fold the byte into the top of the register, then run eight feedback shifts.
    always_comb begin
        w_byte = REFIN ? 8'(reflect(32'(i_byte), 8)) : i_byte;
        w_crc  = i_crc ^ (CRC_WIDTH'(w_byte) << (CRC_WIDTH - 8));
        for (int b = 0; b < 8; b++) begin
            if (w_crc[CRC_WIDTH-1]) begin
                w_crc = (w_crc << 1) ^ POLY;
            end else begin
                w_crc = w_crc << 1;
            end
        end
        o_crc = w_crc;
    end

endmodule

// File: rtl/crc_parallel_engine.sv
// Parallel CRC engine: a chain of NB byte steps per beat, framed valid/ready input,
// result held until taken, plus a residue check for frames that carry their own CRC.
module crc_parallel_engine
    import crc_pkg::*;
#(
    parameter int                   CRC_WIDTH  = 16,
    parameter logic [CRC_WIDTH-1:0] POLY       = 16'h1021,
    parameter logic [CRC_WIDTH-1:0] INIT       = 16'hFFFF,
    parameter bit                   REFIN      = 1'b0,
    parameter bit                   REFOUT     = 1'b0,
    parameter logic [CRC_WIDTH-1:0] XOROUT     = 16'h0000,
    parameter logic [CRC_WIDTH-1:0] RESIDUE    = 16'h0000,
    parameter int                   DATA_WIDTH = 8,
    localparam int                  NB         = DATA_WIDTH / 8,
    localparam int                  NBW        = $clog2(NB + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sof,
    input  logic                  in_eof,
    input  logic [NBW-1:0]        in_nbytes,
    output logic [CRC_WIDTH-1:0]  crc_state,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CRC_WIDTH-1:0]  crc_out,
    output logic                  crc_ok
);

    localparam logic [NBW-1:0] NB_W = NBW'(NB);

    crc_state_e           r_state;
    crc_state_e           w_state_nxt;
    logic [CRC_WIDTH-1:0] r_crc;
    logic [CRC_WIDTH-1:0] r_crc_out;
    logic                 r_crc_ok;
    logic [CRC_WIDTH-1:0] w_tap [NB+1];
    logic [NBW-1:0]       w_k;
    logic [CRC_WIDTH-1:0] w_next;
    logic [CRC_WIDTH-1:0] w_refl;
    logic                 w_accept;
    logic                 w_update;

    // A sof beat always starts from INIT, which also covers a restart in the middle of a frame.
    assign w_tap[0] = in_sof ? INIT : r_crc;

    for (genvar i = 0; i < NB; i++) begin : g_step
        crc_byte_step #(
            .CRC_WIDTH (CRC_WIDTH),
            .POLY      (POLY),
            .REFIN     (REFIN)
        ) u_step (
            .i_crc  (w_tap[i]),
            .i_byte (in_data[8*i +: 8]),
            .o_crc  (w_tap[i+1])
        );
    end

    assign w_accept = in_valid && in_ready;
    assign w_update = w_accept && ((r_state == ST_ACCUM) || in_sof);

    // Pick the tap after the last valid byte; out-of-range byte counts mean a full beat.
    always_comb begin
        if (in_eof && (in_nbytes != '0) && (in_nbytes <= NB_W)) begin
            w_k = in_nbytes;
        end else begin
            w_k = NB_W;
        end
        w_next = w_tap[w_k];
        w_refl = REFOUT ? CRC_WIDTH'(reflect(32'(w_next), CRC_WIDTH)) : w_next;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && in_sof) begin
                    w_state_nxt = in_eof ? ST_HOLD : ST_ACCUM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (w_accept && in_eof) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state and the held result registers.
    always_comb begin
        in_ready  = (r_state != ST_HOLD);
        out_valid = (r_state == ST_HOLD);
        crc_ok    = r_crc_ok && (r_state == ST_HOLD);
        crc_out   = r_crc_out;
        crc_state = r_crc;
    end

    // Running register and result capture on the eof beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc     <= INIT;
            r_crc_out <= '0;
            r_crc_ok  <= 1'b0;
        end else if (w_update) begin
            r_crc <= w_next;
            if (in_eof) begin
                r_crc_out <= w_refl ^ XOROUT;
                r_crc_ok  <= (w_refl == RESIDUE);
            end else begin
                r_crc_out <= r_crc_out;
                r_crc_ok  <= r_crc_ok;
            end
        end else if ((r_state == ST_HOLD) && out_ready) begin
            r_crc     <= INIT;
            r_crc_out <= r_crc_out;
            r_crc_ok  <= r_crc_ok;
        end else begin
            r_crc     <= r_crc;
            r_crc_out <= r_crc_out;
            r_crc_ok  <= r_crc_ok;
        end
    end

endmodule

// File: tb/tb_crc_parallel_engine.sv
// Self-checking bench: four engine configurations driven with random framed traffic and
// compared against a bit-serial polynomial-division reference model.
module tb_crc_parallel_engine;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int          CW_T[4]     = '{16, 16, 16, 32};
    localparam int          DW_T[4]     = '{8, 32, 32, 64};
    localparam logic [31:0] POLY_T[4]   = '{32'h1021, 32'h8005, 32'h8005, 32'h04C11DB7};
    localparam logic [31:0] INIT_T[4]   = '{32'hFFFF, 32'h0000, 32'hFFFF, 32'hFFFFFFFF};
    localparam bit          REFIN_T[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    localparam bit          REFOUT_T[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic [31:0] XOR_T[4]    = '{32'h0000, 32'h0000, 32'h0000, 32'hFFFFFFFF};
    localparam logic [31:0] RES_T[4]    = '{32'h0000, 32'h0000, 32'h0000, 32'hDEBB20E3};
    localparam logic [31:0] KNOWN_T[4]  = '{32'h29B1, 32'hBB3D, 32'h4B37, 32'hCBF43926};

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rev_bits(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[5'(i)] = v[5'(w - 1 - i)];
        return r;
    endfunction

    // Message bits enter one at a time; with input reflection the LSB of each byte goes first.
    function automatic logic [31:0] model_reg(input bq_t msg, input int w, input logic [31:0] poly,
                                              input logic [31:0] init, input bit refin);
        logic [31:0] r, msb, mask;
        logic        d, fb;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        msb  = 32'h1 << (w - 1);
        r    = init & mask;
        foreach (msg[n]) begin
            for (int j = 0; j < 8; j++) begin
                d  = refin ? msg[n][3'(j)] : msg[n][3'(7 - j)];
                fb = d ^ ((r & msb) != 32'h0);
                r  = (r << 1) & mask;
                if (fb) r = r ^ poly;
            end
        end
        return r;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int CW  = CW_T[g];
        localparam int DW  = DW_T[g];
        localparam int NB  = DW / 8;
        localparam int NBW = $clog2(NB + 1);
        localparam logic [CW-1:0] P_POLY = CW'(POLY_T[g]);
        localparam logic [CW-1:0] P_INIT = CW'(INIT_T[g]);
        localparam logic [CW-1:0] P_XOR  = CW'(XOR_T[g]);
        localparam logic [CW-1:0] P_RES  = CW'(RES_T[g]);

        logic          rst = 1'b1, in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0, out_ready = 1'b1;
        logic [DW-1:0] in_data = '0;
        logic [NBW-1:0] in_nbytes = '0;
        logic          in_ready, out_valid, crc_ok;
        logic [CW-1:0] crc_state, crc_out;
        bit            done = 1'b0;

        crc_parallel_engine #(
            .CRC_WIDTH (CW), .POLY (P_POLY), .INIT (P_INIT), .REFIN (REFIN_T[g]),
            .REFOUT (REFOUT_T[g]), .XOROUT (P_XOR), .RESIDUE (P_RES), .DATA_WIDTH (DW)
        ) u_dut (
            .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
            .in_data (in_data), .in_sof (in_sof), .in_eof (in_eof), .in_nbytes (in_nbytes),
            .crc_state (crc_state), .out_valid (out_valid), .out_ready (out_ready),
            .crc_out (crc_out), .crc_ok (crc_ok)
        );

        function automatic string tg(input string s);
            return $sformatf("cfg%0d_%s", g, s);
        endfunction

        task automatic idle();
            in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        endtask

        // Present one beat and hold it until the engine takes it; returns #1 after that edge.
        task automatic put_beat(input logic [DW-1:0] d, input bit sof, input bit eof,
                                input logic [NBW-1:0] nb);
            int guard;
            guard = 0;
            in_valid = 1'b1; in_data = d; in_sof = sof; in_eof = eof; in_nbytes = nb;
            while (!in_ready && guard < 200) begin
                @(posedge clk); #1;
                guard++;
            end
            if (!in_ready) check_val(tg("accept_timeout"), 64'd0, 64'd1);
            @(posedge clk); #1;
        endtask

        task automatic send_frame(input bq_t q, input bit complete);
            int n, nbeats, cnt, sel, maxv;
            logic [DW-1:0]  d;
            logic [NBW-1:0] nb;
            n = q.size();
            nbeats = (n + NB - 1) / NB;
            maxv = (1 << NBW) - 1;
            for (int b = 0; b < nbeats; b++) begin
                for (int i = 0; i < NB; i++)
                    d[8*i +: 8] = (b * NB + i < n) ? q[b * NB + i] : 8'($urandom);
                cnt = (n - b * NB > NB) ? NB : n - b * NB;
                nb  = NBW'(cnt);
                if (b != nbeats - 1) begin
                    nb = NBW'($urandom);
                end else if (cnt == NB) begin
                    sel = $urandom_range(0, 2);
                    if (sel == 1) nb = '0;
                    else if (sel == 2 && maxv > NB) nb = NBW'($urandom_range(NB + 1, maxv));
                end
                put_beat(d, b == 0, complete && (b == nbeats - 1), nb);
                if (b != nbeats - 1 && $urandom_range(0, 3) == 0) begin
                    idle();
                    repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
                end
            end
            idle();
        endtask

        // Called #1 after the eof edge: the result must already be presented.
        task automatic check_result(input bq_t q, input int hold, output logic [CW-1:0] obs_out,
                                    output logic obs_ok);
            logic [31:0] r, f;
            logic [CW-1:0] exp_out;
            r = model_reg(q, CW, POLY_T[g], INIT_T[g], REFIN_T[g]);
            f = REFOUT_T[g] ? rev_bits(r, CW) : r;
            exp_out = CW'(f ^ XOR_T[g]);
            obs_out = crc_out;
            obs_ok  = crc_ok;
            check_val(tg("out_valid"), 64'(out_valid), 64'd1);
            check_val(tg("crc_out"), 64'(crc_out), 64'(exp_out));
            check_val(tg("crc_ok"), 64'(crc_ok), 64'(f == RES_T[g]));
            if (hold > 0) begin
                out_ready = 1'b0;
                in_valid = 1'b1; in_sof = 1'b1; in_eof = 1'b1; in_data = DW'({$urandom, $urandom});
                repeat (hold) begin
                    @(posedge clk); #1;
                    check_val(tg("hold_in_ready"), 64'(in_ready), 64'd0);
                    check_val(tg("hold_out_valid"), 64'(out_valid), 64'd1);
                    check_val(tg("hold_crc_out"), 64'(crc_out), 64'(exp_out));
                end
                idle();
                out_ready = 1'b1;
                @(posedge clk); #1;
                check_val(tg("release_out_valid"), 64'(out_valid), 64'd0);
                check_val(tg("release_state"), 64'(crc_state), 64'(P_INIT));
            end
        endtask

        task automatic check_reset_values(input string s);
            check_val(tg({s, "_in_ready"}), 64'(in_ready), 64'd1);
            check_val(tg({s, "_out_valid"}), 64'(out_valid), 64'd0);
            check_val(tg({s, "_crc_out"}), 64'(crc_out), 64'd0);
            check_val(tg({s, "_crc_ok"}), 64'(crc_ok), 64'd0);
            check_val(tg({s, "_crc_state"}), 64'(crc_state), 64'(P_INIT));
        endtask

        task automatic pulse_reset();
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        endtask

        function automatic bq_t rand_bytes(input int n);
            bq_t q;
            q = {};
            repeat (n) q.push_back(8'($urandom));
            return q;
        endfunction

        initial begin
            bq_t q, q2, qp;
            logic [CW-1:0] o_out;
            logic          o_ok;
            logic [31:0]   kn;
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            check_reset_values("reset");

            // A beat without sof in IDLE is consumed but ignored.
            put_beat(DW'({$urandom, $urandom}), 1'b0, 1'b1, '0);
            idle();
            check_val(tg("drop_out_valid"), 64'(out_valid), 64'd0);
            check_val(tg("drop_state"), 64'(crc_state), 64'(P_INIT));

            // Check string "123456789" against its published CRC, then with the CRC appended.
            q = {};
            for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
            send_frame(q, 1'b1);
            check_result(q, 5, o_out, o_ok);
            check_val(tg("known_crc"), 64'(o_out), 64'(KNOWN_T[g]));
            kn = KNOWN_T[g];
            q2 = q;
            for (int i = 0; i < CW / 8; i++)
                q2.push_back(REFOUT_T[g] ? kn[8*i +: 8] : kn[CW - 8 - 8*i +: 8]);
            send_frame(q2, 1'b1);
            check_result(q2, 0, o_out, o_ok);
            check_val(tg("residue_ok"), 64'(o_ok), 64'd1);
            q2[3] = q2[3] ^ 8'h10;
            send_frame(q2, 1'b1);
            check_result(q2, 1, o_out, o_ok);
            check_val(tg("residue_bad"), 64'(o_ok), 64'd0);

            // Random frames: optional junk beats, aborted prefixes restarted by sof, random hold.
            for (int it = 0; it < 20; it++) begin
                if ($urandom_range(0, 3) == 0) begin
                    put_beat(DW'({$urandom, $urandom}), 1'b0, 1'($urandom), NBW'($urandom));
                    idle();
                end
                if ($urandom_range(0, 3) == 0) begin
                    qp = rand_bytes(NB * $urandom_range(1, 2));
                    send_frame(qp, 1'b0);
                    check_val(tg("abort_out_valid"), 64'(out_valid), 64'd0);
                    check_val(tg("abort_state"), 64'(crc_state),
                              64'(CW'(model_reg(qp, CW, POLY_T[g], INIT_T[g], REFIN_T[g]))));
                end
                q = rand_bytes($urandom_range(1, 3 * NB + 2));
                send_frame(q, 1'b1);
                check_result(q, $urandom_range(0, 3), o_out, o_ok);
            end

            // Reset in the middle of a frame, and again while a result is held.
            qp = rand_bytes(NB * 2);
            send_frame(qp, 1'b0);
            pulse_reset();
            check_reset_values("midframe_rst");
            out_ready = 1'b0;
            q = rand_bytes($urandom_range(1, 2 * NB));
            send_frame(q, 1'b1);
            check_val(tg("pre_rst_out_valid"), 64'(out_valid), 64'd1);
            pulse_reset();
            out_ready = 1'b1;
            check_reset_values("hold_rst");

            for (int it = 0; it < 4; it++) begin
                q = rand_bytes($urandom_range(1, 2 * NB + 3));
                send_frame(q, 1'b1);
                check_result(q, $urandom_range(0, 2), o_out, o_ok);
            end
            done = 1'b1;
        end
    end

    initial begin
        int guard;
        guard = 0;
        while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done)
               && guard < 50000) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 50000) check_val("global_timeout", 64'd0, 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
